// File: rtl/radix2_cplx_butterfly.sv
// rtl/radix2_cplx_butterfly.sv - 4-stage pipelined complex radix-2 DIT butterfly: X = A + W*B, Y = A - W*B
// Optional: define RADIX2_CPLX_BFLY_ROUND_EN for round-half-up on every right shift (default truncates).
module radix2_cplx_butterfly #(
  parameter int DATA_WIDTH    = 16,
  parameter int TWIDDLE_WIDTH = 16,
  parameter int TAG_WIDTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enIn,
  input  logic                           validIn,
  input  logic signed [DATA_WIDTH-1:0]    aReIn,
  input  logic signed [DATA_WIDTH-1:0]    aImIn,
  input  logic signed [DATA_WIDTH-1:0]    bReIn,
  input  logic signed [DATA_WIDTH-1:0]    bImIn,
  input  logic signed [TWIDDLE_WIDTH-1:0] wReIn,
  input  logic signed [TWIDDLE_WIDTH-1:0] wImIn,
  input  logic [1:0]                     scaleIn,
  input  logic [TAG_WIDTH-1:0]           tagIn,
  output logic                           validOut,
  output logic signed [DATA_WIDTH+1:0]    xReOut,
  output logic signed [DATA_WIDTH+1:0]    xImOut,
  output logic signed [DATA_WIDTH+1:0]    yReOut,
  output logic signed [DATA_WIDTH+1:0]    yImOut,
  output logic [TAG_WIDTH-1:0]           tagOut
);

  localparam int PW = DATA_WIDTH + TWIDDLE_WIDTH;
  localparam int WW = DATA_WIDTH + 1;
  localparam int OW = DATA_WIDTH + 2;

`ifdef RADIX2_CPLX_BFLY_ROUND_EN
  // One extra bit so the half-LSB addend can never carry into the sign.
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] PROD_RND = SW'(1) << (TWIDDLE_WIDTH - 2);
`else
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] PROD_RND = '0;
`endif

  // Output scaling: shift by 0..2, with code 3 clamped to 2.
  function automatic logic signed [OW-1:0] scale_shift(input logic signed [OW-1:0] v,
                                                      input logic [1:0] s);
    logic [1:0]          sh;
    logic signed [OW:0]  e;
    logic signed [OW:0]  rnd;
    sh  = (s == 2'd3) ? 2'd2 : s;
    e   = {v[OW-1], v};
    rnd = '0;
`ifdef RADIX2_CPLX_BFLY_ROUND_EN
    if (sh != 2'd0) rnd[sh - 2'd1] = 1'b1;
`endif
    e = (e + rnd) >>> sh;
    return e[OW-1:0];
  endfunction

  logic                            r1_valid, r2_valid, r3_valid, r4_valid;
  logic [1:0]                      r1_scale, r2_scale, r3_scale;
  logic [TAG_WIDTH-1:0]            r1_tag, r2_tag, r3_tag, r4_tag;
  logic signed [DATA_WIDTH-1:0]    r1_are, r1_aim, r1_bre, r1_bim;
  logic signed [TWIDDLE_WIDTH-1:0] r1_wre, r1_wim;
  logic signed [DATA_WIDTH-1:0]    r2_are, r2_aim;
  logic signed [PW-1:0]            r2_prr, r2_pii, r2_pri, r2_pir;
  logic signed [OW-1:0]            r3_xre, r3_xim, r3_yre, r3_yim;
  logic signed [OW-1:0]            r4_xre, r4_xim, r4_yre, r4_yim;

  logic signed [SW-1:0]            w_sum_re, w_sum_im;
  logic signed [WW-1:0]            w_wb_re, w_wb_im;
  logic signed [OW-1:0]            w_x_re, w_x_im, w_y_re, w_y_im;
  logic                            w_unused;

  assign w_sum_re = {{(SW-PW){r2_prr[PW-1]}}, r2_prr} - {{(SW-PW){r2_pii[PW-1]}}, r2_pii} + PROD_RND;
  assign w_sum_im = {{(SW-PW){r2_pri[PW-1]}}, r2_pri} + {{(SW-PW){r2_pir[PW-1]}}, r2_pir} + PROD_RND;

  // Arithmetic shift by TWIDDLE_WIDTH-1 and narrowing to DATA_WIDTH+1 in one slice.
  assign w_wb_re = w_sum_re[TWIDDLE_WIDTH-1 +: WW];
  assign w_wb_im = w_sum_im[TWIDDLE_WIDTH-1 +: WW];

  assign w_x_re = {{2{r2_are[DATA_WIDTH-1]}}, r2_are} + {w_wb_re[WW-1], w_wb_re};
  assign w_x_im = {{2{r2_aim[DATA_WIDTH-1]}}, r2_aim} + {w_wb_im[WW-1], w_wb_im};
  assign w_y_re = {{2{r2_are[DATA_WIDTH-1]}}, r2_are} - {w_wb_re[WW-1], w_wb_re};
  assign w_y_im = {{2{r2_aim[DATA_WIDTH-1]}}, r2_aim} - {w_wb_im[WW-1], w_wb_im};

  assign w_unused = ^{w_sum_re[TWIDDLE_WIDTH-2:0], w_sum_re[SW-1:TWIDDLE_WIDTH-1+WW],
                      w_sum_im[TWIDDLE_WIDTH-2:0], w_sum_im[SW-1:TWIDDLE_WIDTH-1+WW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0; r1_scale <= '0; r1_tag <= '0;
      r1_are   <= '0;   r1_aim   <= '0; r1_bre <= '0; r1_bim <= '0;
      r1_wre   <= '0;   r1_wim   <= '0;
      r2_valid <= 1'b0; r2_scale <= '0; r2_tag <= '0;
      r2_are   <= '0;   r2_aim   <= '0;
      r2_prr   <= '0;   r2_pii   <= '0; r2_pri <= '0; r2_pir <= '0;
      r3_valid <= 1'b0; r3_scale <= '0; r3_tag <= '0;
      r3_xre   <= '0;   r3_xim   <= '0; r3_yre <= '0; r3_yim <= '0;
      r4_valid <= 1'b0; r4_tag   <= '0;
      r4_xre   <= '0;   r4_xim   <= '0; r4_yre <= '0; r4_yim <= '0;
    end else if (enIn) begin
      r1_valid <= validIn; r1_scale <= scaleIn; r1_tag <= tagIn;
      r1_are   <= aReIn;   r1_aim   <= aImIn;   r1_bre <= bReIn; r1_bim <= bImIn;
      r1_wre   <= wReIn;   r1_wim   <= wImIn;

      r2_valid <= r1_valid; r2_scale <= r1_scale; r2_tag <= r1_tag;
      r2_are   <= r1_are;   r2_aim   <= r1_aim;
      r2_prr   <= r1_bre * r1_wre;
      r2_pii   <= r1_bim * r1_wim;
      r2_pri   <= r1_bre * r1_wim;
      r2_pir   <= r1_bim * r1_wre;

      r3_valid <= r2_valid; r3_scale <= r2_scale; r3_tag <= r2_tag;
      r3_xre   <= w_x_re;   r3_xim   <= w_x_im;
      r3_yre   <= w_y_re;   r3_yim   <= w_y_im;

      r4_valid <= r3_valid; r4_tag   <= r3_tag;
      r4_xre   <= scale_shift(r3_xre, r3_scale);
      r4_xim   <= scale_shift(r3_xim, r3_scale);
      r4_yre   <= scale_shift(r3_yre, r3_scale);
      r4_yim   <= scale_shift(r3_yim, r3_scale);
    end
  end

  assign validOut = r4_valid;
  assign tagOut   = r4_tag;
  assign xReOut   = r4_xre;
  assign xImOut   = r4_xim;
  assign yReOut   = r4_yre;
  assign yImOut   = r4_yim;

endmodule

// File: doc/radix2_cplx_butterfly.md
# radix2_cplx_butterfly

Pipelined complex radix-2 decimation-in-time butterfly for the FFT core. Each accepted sample computes X = A + W·B and Y = A − W·B on complex operands. Full bit growth is kept, and a per-sample right-shift scaling control is applied. It is the arithmetic element instantiated once per FFT stage, downstream of the stage's sample reorder buffer and twiddle ROM. It generalises the single-channel real butterfly with complex data, twiddle multiplication, selectable scaling, clock-enable stall and tag passthrough.

## Interface
- DATA_WIDTH, 16, width of each signed real/imag input component
- TWIDDLE_WIDTH, 16, width of each signed twiddle component, format Q1.(TWIDDLE_WIDTH−1)
- TAG_WIDTH, 8, width of sideband tag carried alongside each sample
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enIn  in  1  pipeline clock enable; 0 freezes every register
- validIn  in  1  input sample valid
- aReIn, aImIn  in  DATA_WIDTH each  operand A, signed
- bReIn, bImIn  in  DATA_WIDTH each  operand B, signed
- wReIn, wImIn  in  TWIDDLE_WIDTH each  twiddle W, signed
- scaleIn  in  2  output right-shift amount 0..2; value 3 behaves as 2
- tagIn  in  TAG_WIDTH  sideband tag
- validOut  out  1  output sample valid
- xReOut, xImOut, yReOut, yImOut  out  DATA_WIDTH+2 each  results, signed
- tagOut  out  TAG_WIDTH  tag aligned with results

## Operation
- Stage 1 registers all inputs, validIn, scaleIn and tagIn.
- Stage 2 registers the four products bRe·wRe, bIm·wIm, bRe·wIm and bIm·wRe at full width DATA_WIDTH+TWIDDLE_WIDTH.
- Stage 3 forms the complex product W·B:
  - Real part pRe = bRe·wRe − bIm·wIm; imaginary part pIm = bRe·wIm + bIm·wRe.
  - Each sum is computed at DATA_WIDTH+TWIDDLE_WIDTH+1 bits.
  - Each sum is reduced by arithmetic shift of TWIDDLE_WIDTH−1 (rounding per Configuration) to DATA_WIDTH+1 bits, giving wbRe and wbIm.
  - X = A + WB and Y = A − WB are computed sign-extended to DATA_WIDTH+2 bits and registered.
- Stage 4 arithmetic-shifts each of the four results right by the registered scale (rounding per Configuration) and registers them at DATA_WIDTH+2 bits.
- No saturation anywhere. |W| ≤ 1 guarantees there is no overflow at DATA_WIDTH+2 bits. W = −1 is exact with twiddle −2^(TW−1).
- Data registers load on every enabled edge regardless of valid. Output data is defined only while validOut = 1.

## Timing
- Latency: exactly 4 enabled clock edges from validIn sampled to validOut.
- Throughput: one sample per enabled cycle, no bubbles.
- enIn = 0: all stage registers, including valid and tag, hold. Outputs are stable.
- rst = 1 at a clock edge:
  - All registers clear to 0 regardless of enIn.
  - Reset values: validOut=0, xReOut=0, xImOut=0, yReOut=0, yImOut=0, tagOut=0.
- Reset mid-operation drops all in-flight samples. The first input after rst deasserts appears 4 enabled cycles later.
- Simultaneous rst and enIn: rst wins.
- Scale, tag and valid travel with their sample. Changing scaleIn every cycle affects only the sample it accompanies.

## Configuration
- RADIX2_CPLX_BFLY_ROUND_EN defined:
  - Every right shift (product reduction and output scaling) is round-half-up: add 2^(s−1) before shifting by s. No add when s = 0.
  - Adder widths are sized so the rounding addend cannot overflow.
- Not defined: every right shift truncates (floor, plain arithmetic shift).

## Test plan
(DATA_WIDTH=16, TWIDDLE_WIDTH=16)
- A=(100,200), B=(30,−40), W=(16384,0), scale 0 → X=(115,180), Y=(85,220), validOut 4 cycles after validIn, tag 0x5A preserved.
- B=(31,0), W=(16384,0), A=(0,0), scale 0 → X=(16,0), Y=(−16,0) with ROUND_EN; without ROUND_EN → X=(15,0), Y=(−15,0).
- Extremes: A=(32767,32767), B=(−32768,−32768), W=(−32768,0) → X=(65535,65535), Y=(−1,−1) with no wrap.
- Scaling: A=(100,200), B=(30,−40), W=(16384,0), scale 2, no ROUND_EN → X=(28,45), Y=(21,55). Also check scale 3 gives the same result as scale 2.
- Stall: stream 10 consecutive valid samples with enIn toggled in the pattern 1,0,0,1. Outputs must hold during enIn=0, and all 10 results must arrive in order, correct and without duplicates.
- Reset mid-stream: assert rst for 1 cycle with 3 samples in flight. validOut must be 0 on the next cycle and every output register 0. No in-flight sample may ever emerge, and a new sample emerges 4 cycles after rst deasserts.
